// File: rtl/memory_grant_arbiter.sv
// Shared data-memory arbiter between the host CPU port and the coprocessor, with a turnaround gap between owners.
// Optional grant-hold timeout is enabled by defining ARB_TIMEOUT_EN.
module memory_grant_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 256
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Cpu_Request,
    input  logic [ADDR_WIDTH-1:0] i_Cpu_Address,
    input  logic [DATA_WIDTH-1:0] i_Cpu_Write_Data,
    input  logic                  i_Cpu_Write_Enable,
    input  logic                  i_Cop_Request,
    input  logic [ADDR_WIDTH-1:0] i_Cop_Address,
    input  logic [DATA_WIDTH-1:0] i_Cop_Write_Data,
    input  logic                  i_Cop_Write_Enable,
    input  logic [DATA_WIDTH-1:0] i_Mem_Read_Data,
    output logic                  o_Cpu_Grant,
    output logic                  o_Cop_Grant,
    output logic [ADDR_WIDTH-1:0] o_Mem_Address,
    output logic [DATA_WIDTH-1:0] o_Mem_Write_Data,
    output logic                  o_Mem_Write_Enable,
    output logic [DATA_WIDTH-1:0] o_Read_Data,
    output logic                  o_Busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_GRANT_CPU = 2'd1,
        S_GRANT_COP = 2'd2,
        S_TURN      = 2'd3
    } state_t;

    localparam int                TURN_W    = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_ptr_cop;
    logic              w_next_ptr_cop;
    logic [TURN_W-1:0] r_turn_cnt;
    logic              w_cpu_timeout;
    logic              w_cop_timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_holding;

    assign w_holding = (r_state == w_next_state) &&
                       ((r_state == S_GRANT_CPU) || (r_state == S_GRANT_COP));

    // Cleared on every new grant; saturates so an uncontested owner keeps the bus.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_hold_cnt <= '0;
        end else if (w_holding) begin
            if (r_hold_cnt != HOLD_LAST) r_hold_cnt <= r_hold_cnt + 1'b1;
        end else begin
            r_hold_cnt <= '0;
        end
    end

    assign w_cpu_timeout = (r_hold_cnt == HOLD_LAST) && i_Cop_Request;
    assign w_cop_timeout = (r_hold_cnt == HOLD_LAST) && i_Cpu_Request;
`else
    assign w_cpu_timeout = 1'b0;
    assign w_cop_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_ptr_cop  <= 1'b0;
            r_turn_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_ptr_cop <= w_next_ptr_cop;
            if ((r_state == S_TURN) && (w_next_state == S_TURN)) r_turn_cnt <= r_turn_cnt + 1'b1;
            else                                                r_turn_cnt <= '0;
        end
    end

    // NOTE: defaults first in every combinational block so no path infers a latch.
    always_comb begin
        w_next_state   = r_state;
        w_next_ptr_cop = r_ptr_cop;
        case (r_state)
            S_IDLE: begin
                if (i_Cpu_Request && i_Cop_Request) begin
                    w_next_state   = r_ptr_cop ? S_GRANT_COP : S_GRANT_CPU;
                    w_next_ptr_cop = ~r_ptr_cop;
                end else if (i_Cpu_Request) begin
                    w_next_state = S_GRANT_CPU;
                end else if (i_Cop_Request) begin
                    w_next_state = S_GRANT_COP;
                end
            end
            S_GRANT_CPU: begin
                if (!i_Cpu_Request) begin
                    w_next_state = S_TURN;
                end else if (w_cpu_timeout) begin
                    w_next_state   = S_TURN;
                    w_next_ptr_cop = 1'b1;
                end
            end
            S_GRANT_COP: begin
                if (!i_Cop_Request) begin
                    w_next_state = S_TURN;
                end else if (w_cop_timeout) begin
                    w_next_state   = S_TURN;
                    w_next_ptr_cop = 1'b0;
                end
            end
            S_TURN: begin
                if (r_turn_cnt == TURN_LAST) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Memory mux follows the registered owner only, so a non-owner strobe can never leak through.
    always_comb begin
        o_Cpu_Grant        = (r_state == S_GRANT_CPU);
        o_Cop_Grant        = (r_state == S_GRANT_COP);
        o_Busy             = (r_state != S_IDLE);
        o_Mem_Address      = '0;
        o_Mem_Write_Data   = '0;
        o_Mem_Write_Enable = 1'b0;
        case (r_state)
            S_GRANT_CPU: begin
                o_Mem_Address      = i_Cpu_Address;
                o_Mem_Write_Data   = i_Cpu_Write_Data;
                o_Mem_Write_Enable = i_Cpu_Write_Enable;
            end
            S_GRANT_COP: begin
                o_Mem_Address      = i_Cop_Address;
                o_Mem_Write_Data   = i_Cop_Write_Data;
                o_Mem_Write_Enable = i_Cop_Write_Enable;
            end
            default: ;
        endcase
    end

    assign o_Read_Data = i_Mem_Read_Data;

endmodule
